// File: rtl/burst_request_sequencer.sv
// burst_request_sequencer: splits a multi-word write request into BURST_LEN-word
// BurstMode transactions, feeding DataIn from an internal data FIFO.
// Optional feature macro: BURST_SEQ_TIMEOUT_EN (CE-to-Done watchdog, drives Error).
module burst_request_sequencer #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 16,
    parameter int BURST_LEN      = 4,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_W          = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] ReqAddress,
    input  logic [CNT_W-1:0]  ReqWords,
    input  logic [DATA_W-1:0] WrData,
    input  logic              WrValid,
    output logic              WrReady,
    output logic              Busy,
    output logic              SeqDone,
    output logic              Underrun,
    output logic              Error,
    output logic [DATA_W-1:0] DataIn,
    output logic [ADDR_W-1:0] AddressIn,
    output logic              CE,
    input  logic              Yield,
    input  logic              Done
);

    localparam int LG_BURST = $clog2(BURST_LEN);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < BURST_LEN || TIMEOUT_CYCLES < 2) begin : gBadParams
        $error("burst_request_sequencer: FIFO_DEPTH must be >= BURST_LEN and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        sIdle, sFill, sIssue, sWait, sNext, sFinish
    } seqState_t;

    seqState_t state, nextState;

    logic              rstSeen;
    logic [ADDR_W-1:0] addrReg;
    logic [CNT_W-1:0]  burstsLeft;
    logic [CNT_W-1:0]  reqBursts;
    logic              underrunReg;
    logic              accept;
    logic              timeoutHit;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr;
    logic [PTR_W:0]    fifoCount;
    logic [DATA_W-1:0] dataHold;
    logic              fifoEmpty, push, pop;

    assign reqBursts = ReqWords >> LG_BURST;
    assign accept    = ReqValid & ReqReady;
    assign fifoEmpty = (fifoCount == '0);
    assign push      = WrValid & WrReady;
    assign pop       = (state == sWait) & Yield & ~fifoEmpty;

    assign ReqReady  = (state == sIdle) & ~rstSeen;
    assign WrReady   = (fifoCount != (PTR_W+1)'(FIFO_DEPTH));
    assign Busy      = (state != sIdle);
    assign SeqDone   = (state == sFinish);
    assign CE        = (state == sIssue);
    assign Underrun  = underrunReg;
    assign AddressIn = addrReg;
    // When empty, DataIn keeps showing the last word handed to BurstMode.
    assign DataIn    = fifoEmpty ? dataHold : mem[rdPtr];

    // State register; rstSeen keeps ReqReady low for the cycle RST is sampled high.
    always_ff @(posedge CLK) begin
        rstSeen <= RST;
        if (RST) state <= sIdle;
        else     state <= nextState;
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            sIdle:   if (accept) nextState = (reqBursts == '0) ? sFinish : sFill;
            sFill:   if (fifoCount >= (PTR_W+1)'(BURST_LEN)) nextState = sIssue;
            sIssue:  nextState = sWait;
            sWait: begin
                if (Done)            nextState = sNext;
                else if (timeoutHit) nextState = sFinish;
            end
            sNext:   nextState = (burstsLeft == CNT_W'(1)) ? sFinish : sFill;
            sFinish: nextState = sIdle;
            default: nextState = sIdle;
        endcase
    end

    // Request address / burst counter and sticky underrun flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            addrReg     <= '0;
            burstsLeft  <= '0;
            underrunReg <= 1'b0;
        end else begin
            if (accept) begin
                addrReg     <= ReqAddress;
                burstsLeft  <= reqBursts;
                underrunReg <= 1'b0;
            end
            if (state == sNext) begin
                addrReg    <= addrReg + ADDR_W'(BURST_LEN);
                burstsLeft <= burstsLeft - CNT_W'(1);
            end
            if (state == sWait && Yield && fifoEmpty) underrunReg <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; a watchdog abort flushes like reset.
    always_ff @(posedge CLK) begin
        if (RST || timeoutHit) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + (PTR_W+1)'(1);
                2'b01:   fifoCount <= fifoCount - (PTR_W+1)'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // FIFO storage (no reset needed; reads are masked by fifoEmpty).
    always_ff @(posedge CLK) begin
        if (push) mem[wrPtr] <= WrData;
    end

    // Last popped word, shown on DataIn while the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (RST)      dataHold <= '0;
        else if (pop) dataHold <= mem[rdPtr];
    end

`ifdef BURST_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wdCount;
    logic            errorReg;

    // wdCount equals cycles since CE while in WAIT; abort lands FINISH TIMEOUT_CYCLES after CE.
    assign timeoutHit = (state == sWait) & ~Done & (wdCount == WD_W'(TIMEOUT_CYCLES - 1));
    assign Error      = errorReg;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wdCount  <= '0;
            errorReg <= 1'b0;
        end else begin
            if (state == sIssue)     wdCount <= WD_W'(1);
            else if (state == sWait) wdCount <= wdCount + WD_W'(1);
            if (accept)     errorReg <= 1'b0;
            if (timeoutHit) errorReg <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign Error      = 1'b0;
`endif

endmodule
